// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - shared types and constants for the sequential multiplier
package mul_seq_pkg;

    localparam int MUL_ITERS = 32;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MLA   = 2'b01,
        OP_UMULL = 2'b10,
        OP_SMULL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // Long ops report flags over all 64 bits, short ops over the low word only.
    function automatic logic is_long(input op_e o);
        return (o == OP_UMULL) || (o == OP_SMULL);
    endfunction

endpackage

// File: rtl/mul_seq_step.sv
// rtl/mul_seq_step.sv - one shift-and-add multiplication iteration
module mul_step (
    input  logic [63:0] mcand_i,
    input  logic [31:0] mplier_i,
    input  logic [63:0] prod_i,
    output logic [63:0] mcand_o,
    output logic [31:0] mplier_o,
    output logic [63:0] prod_o
);

    // Add the aligned multiplicand when the current multiplier bit is set, then advance both.
    always_comb begin
        prod_o   = mplier_i[0] ? (prod_i + mcand_i) : prod_i;
        mcand_o  = {mcand_i[62:0], 1'b0};
        mplier_o = {1'b0, mplier_i[31:1]};
    end

endmodule

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - 32x32 sequential multiplier with MUL/MLA/UMULL/SMULL ops
module mul_seq
    import mul_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] acc,
    output logic        busy,
    output logic        done,
    output logic [63:0] result,
    output logic        n_flag,
    output logic        z_flag
);

    localparam logic [4:0] LAST_ITER = 5'(MUL_ITERS - 1);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [63:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [63:0] prod_q, prod_d;
    logic        sign_q, sign_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [63:0] result_q, result_d;
    logic        n_q, n_d;
    logic        z_q, z_d;

    logic [63:0] step_mcand;
    logic [31:0] step_mplier;
    logic [63:0] step_prod;

    mul_step u_step (
        .mcand_i  (mcand_q),
        .mplier_i (mplier_q),
        .prod_i   (prod_q),
        .mcand_o  (step_mcand),
        .mplier_o (step_mplier),
        .prod_o   (step_prod)
    );

    // Next-state, datapath and registered-output computation for the whole FSM.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        sign_d   = sign_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        result_d = result_q;
        n_d      = n_q;
        z_d      = z_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d     = op_e'(op);
                    cnt_d    = 5'd0;
                    mcand_d  = {32'b0, a};
                    mplier_d = b;
                    sign_d   = 1'b0;
                    prod_d   = (op_e'(op) == OP_MLA) ? {32'b0, acc} : 64'd0;
                    if (op_e'(op) == OP_SMULL) begin
                        // 0x80000000 negates to itself, which reads correctly as unsigned 2^31.
                        mcand_d  = {32'b0, (a[31] ? (~a + 32'd1) : a)};
                        mplier_d = b[31] ? (~b + 32'd1) : b;
                        sign_d   = a[31] ^ b[31];
                    end
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                mcand_d  = step_mcand;
                mplier_d = step_mplier;
                prod_d   = step_prod;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (op_q == OP_SMULL && sign_q) begin
                    prod_d = ~prod_q + 64'd1;
                end else if (!is_long(op_q)) begin
                    prod_d = {32'b0, prod_q[31:0]};
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                result_d = prod_q;
                done_d   = 1'b1;
                if (is_long(op_q)) begin
                    n_d = prod_q[63];
                    z_d = (prod_q == 64'd0);
                end else begin
                    n_d = prod_q[31];
                    z_d = (prod_q[31:0] == 32'd0);
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State register with synchronous active-low reset that aborts any operation.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            mcand_q  <= 64'd0;
            mplier_q <= 32'd0;
            prod_q   <= 64'd0;
            sign_q   <= 1'b0;
            cnt_q    <= 5'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 64'd0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            sign_q   <= sign_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            n_q      <= n_d;
            z_q      <= z_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign n_flag = n_q;
    assign z_flag = z_q;

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - randomized self-checking bench for mul_seq
module tb_mul_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [31:0] acc = 32'd0;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        n_flag;
    logic        z_flag;

    int n_checks = 0;
    int n_errors = 0;

    mul_seq dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .acc    (acc),
        .busy   (busy),
        .done   (done),
        .result (result),
        .n_flag (n_flag),
        .z_flag (z_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y, input logic [31:0] z);
        logic [31:0] lo;
        longint      s;
        case (o)
            2'b00: begin lo = x * y; return {32'b0, lo}; end
            2'b01: begin lo = x * y + z; return {32'b0, lo}; end
            2'b10: return {32'b0, x} * {32'b0, y};
            default: begin
                s = longint'($signed(x)) * longint'($signed(y));
                return 64'(s);
            end
        endcase
    endfunction

    function automatic logic ref_n(input logic [1:0] o, input logic [63:0] r);
        return o[1] ? r[63] : r[31];
    endfunction

    function automatic logic ref_z(input logic [1:0] o, input logic [63:0] r);
        return o[1] ? (r == 64'd0) : (r[31:0] == 32'd0);
    endfunction

    // poke_at: cycle at which a competing start is pulsed; reset_at: cycle at which reset is pulled.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] ra,
                          input logic [31:0] rb, input logic [31:0] racc,
                          input int poke_at, input int reset_at);
        logic [63:0] exp_r;
        int          done_cyc;
        logic        busy_ok;
        exp_r    = ref_mul(o, ra, rb, racc);
        done_cyc = -1;
        busy_ok  = 1'b1;
        op = o; a = ra; b = rb; acc = racc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k == poke_at) begin
                start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom; acc = $urandom;
            end else begin
                start = 1'b0;
            end
            if (k == reset_at) reset = 1'b0;
            @(posedge clk); #1;
            if (k == reset_at) begin
                check({tag, " abort done"}, 64'(done), 64'd0);
                check({tag, " abort busy"}, 64'(busy), 64'd0);
                check({tag, " abort result"}, result, 64'd0);
                check({tag, " abort flags"}, {62'd0, n_flag, z_flag}, 64'd0);
                // start presented while reset is low must not be taken
                start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
                @(posedge clk); #1;
                check({tag, " start in reset"}, 64'(busy), 64'd0);
                start = 1'b0;
                reset = 1'b1;
                return;
            end
            if (done) begin
                done_cyc = k;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        start = 1'b0;
        check({tag, " latency"}, 64'(done_cyc), 64'd34);
        check({tag, " busy held"}, 64'(busy_ok), 64'd1);
        check({tag, " result"}, result, exp_r);
        check({tag, " flags"}, {62'd0, n_flag, z_flag}, {62'd0, ref_n(o, exp_r), ref_z(o, exp_r)});
    endtask

    initial begin
        logic [31:0] corner [6];
        corner[0] = 32'h0000_0000; corner[1] = 32'hFFFF_FFFF; corner[2] = 32'h8000_0000;
        corner[3] = 32'h7FFF_FFFF; corner[4] = 32'h0000_0001; corner[5] = 32'h0001_0000;

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset result", result, 64'd0);
        check("reset flags", {62'd0, n_flag, z_flag}, 64'd0);
        reset = 1'b1;

        run_op("mul 3x5", 2'b00, 32'd3, 32'd5, 32'd0, 0, 0);
        check("mul 3x5 const", result, 64'h0000_0000_0000_000F);
        run_op("umull ffff", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 0, 0);
        check("umull ffff const", result, 64'hFFFF_FFFE_0000_0001);
        run_op("smull -1x2", 2'b11, 32'hFFFF_FFFF, 32'd2, 32'd0, 0, 0);
        check("smull -1x2 const", result, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("mla 7x6+100", 2'b01, 32'd7, 32'd6, 32'd100, 0, 0);
        check("mla 7x6+100 const", result, 64'h0000_0000_0000_008E);
        run_op("mla wrap", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 0);
        check("mla wrap z", 64'(z_flag), 64'd1);
        run_op("smull min", 2'b11, 32'h8000_0000, 32'h8000_0000, 32'd0, 0, 0);
        check("smull min const", result, 64'h4000_0000_0000_0000);

        run_op("ignored start", 2'b10, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 10, 0);
        run_op("reset abort", 2'b11, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'd0, 0, 15);
        run_op("mul 2x2 after reset", 2'b00, 32'd2, 32'd2, 32'd0, 0, 0);
        check("mul 2x2 const", result, 64'd4);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rb, rc;
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            rc = $urandom;
            run_op($sformatf("rand%0d", i), 2'($urandom), ra, rb, rc, 0, 0);
        end

        @(posedge clk); #1;
        check("done pulse ends", 64'(done), 64'd0);
        check("idle busy", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
